// File: rtl/luma_threshold_scheduler_pkg.sv
// Shared types and constants for the luma threshold calibration controller.
package luma_threshold_scheduler_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 17;
    localparam int SUM_W = 25;

    localparam int IMAGE_WIDTH = 384;
    localparam int IMAGE_HIGHT = 216;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_SCAN     = 3'd2,
        ST_DIV_LO   = 3'd3,
        ST_DIV_HI   = 3'd4,
        ST_UPDATE   = 3'd5,
        ST_RUN      = 3'd6
    } state_e;

    // Magnitude of the difference between two luma codes.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/luma_threshold_scheduler_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; SUM_W cycles later done pulses for one
// cycle and quotient holds the low PIX_W bits of the floored result.
module seq_divider
    import luma_threshold_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [PIX_W-1:0] quotient,
    output logic             done
);

    logic [SUM_W-1:0] acc_q, acc_d;    // dividend shifts out, quotient shifts in
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [4:0]       step_q, step_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   trial;

    // Load on start, then one shift-subtract step per cycle.
    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        step_d = step_q;
        done_d = 1'b0;
        trial  = {rem_q, acc_q[SUM_W-1]};
        if (start) begin
            acc_d  = dividend;
            rem_d  = '0;
            step_d = 5'(SUM_W);
        end else if (step_q != 5'd0) begin
            if (trial >= {1'b0, divisor}) begin
                rem_d = trial[CNT_W-1:0] - divisor;
                acc_d = {acc_q[SUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial[CNT_W-1:0];
                acc_d = {acc_q[SUM_W-2:0], 1'b0};
            end
            step_d = step_q - 5'd1;
            if (step_q == 5'd1) done_d = 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            rem_q  <= '0;
            step_q <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            step_q <= step_d;
            done_q <= done_d;
        end
    end

    assign quotient = acc_q[PIX_W-1:0];
    assign done     = done_q;

endmodule

// File: rtl/luma_threshold_scheduler.sv
// Per-frame isodata calibration of the decider's class_1/class_2 thresholds.
// Scans whole frames, splits pixels by the current threshold, divides the
// class sums by their counts, and hands off to the decider once converged.
module luma_threshold_scheduler
    import luma_threshold_scheduler_pkg::*;
#(
    parameter int               IMAGE_WIDTH = luma_threshold_scheduler_pkg::IMAGE_WIDTH,
    parameter int               IMAGE_HIGHT = luma_threshold_scheduler_pkg::IMAGE_HIGHT,
    parameter int               MAX_ITER    = 8,
    parameter int               CONV_TOL    = 1,
    parameter logic [PIX_W-1:0] INIT_C1     = 8'd64,
    parameter logic [PIX_W-1:0] INIT_C2     = 8'd192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] luma_ch,
    output logic [PIX_W-1:0] class_1,
    output logic [PIX_W-1:0] class_2,
    output logic             decide_en,
    output logic             decider_rst,
    output logic             busy,
    output logic [3:0]       iter_cnt,
    output logic [2:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(IMAGE_WIDTH * IMAGE_HIGHT - 1);
    localparam logic [3:0]       MAX_ITER_C = 4'(MAX_ITER);
    localparam logic [PIX_W-1:0] TOL_C      = PIX_W'(CONV_TOL);

    // Pixel stream handshake: a sample is consumed on every cycle where
    // pix_valid is high; there is no backpressure, so gaps simply stall.

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pix_idx_q, pix_idx_d;
    logic [SUM_W-1:0] lo_sum_q, lo_sum_d, hi_sum_q, hi_sum_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [PIX_W-1:0] new_lo_q, new_lo_d, new_hi_q, new_hi_d;
    logic [PIX_W-1:0] class_1_q, class_1_d, class_2_q, class_2_d;
    logic [3:0]       iter_q, iter_d;
    logic             div_run_q, div_run_d;
    logic             en_q, en_d, drst_q, drst_d, busy_q, busy_d;

    logic             acc_en, div_start, div_done, is_dark, converged;
    logic [PIX_W-1:0] th, div_quot;
    logic [SUM_W-1:0] div_dividend;
    logic [CNT_W-1:0] div_divisor;

    // Same floored threshold the decider uses.
    assign th        = (class_1_q >> 1) + (class_2_q >> 1);
    assign is_dark   = (luma_ch < th);
    assign converged = (abs_diff(new_lo_q, class_1_q) <= TOL_C) &&
                       (abs_diff(new_hi_q, class_2_q) <= TOL_C);

    // One divider serves both classes; the state selects the operands.
    assign div_dividend = (state_q == ST_DIV_HI) ? hi_sum_q : lo_sum_q;
    assign div_divisor  = (state_q == ST_DIV_HI) ? hi_cnt_q : lo_cnt_q;

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

    // Calibration FSM and accumulator next-state logic.
    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        lo_sum_d  = lo_sum_q;
        hi_sum_d  = hi_sum_q;
        lo_cnt_d  = lo_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        new_lo_d  = new_lo_q;
        new_hi_d  = new_hi_q;
        class_1_d = class_1_q;
        class_2_d = class_2_q;
        iter_d    = iter_q;
        div_run_d = div_run_q;
        en_d      = en_q;
        drst_d    = 1'b0;
        busy_d    = busy_q;
        acc_en    = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (sof && pix_valid) begin
                    acc_en    = 1'b1;
                    pix_idx_d = CNT_W'(1);
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (pix_valid) begin
                    acc_en    = 1'b1;
                    pix_idx_d = pix_idx_q + CNT_W'(1);
                    if (pix_idx_q == LAST_PIX) state_d = ST_DIV_LO;
                end
            end
            ST_DIV_LO: begin
                if (lo_cnt_q == '0) begin
                    new_lo_d = class_1_q;          // empty class keeps its mean
                    state_d  = ST_DIV_HI;
                end else if (!div_run_q) begin
                    div_start = 1'b1;
                    div_run_d = 1'b1;
                end else if (div_done) begin
                    new_lo_d  = div_quot;
                    div_run_d = 1'b0;
                    state_d   = ST_DIV_HI;
                end
            end
            ST_DIV_HI: begin
                if (hi_cnt_q == '0) begin
                    new_hi_d = class_2_q;
                    state_d  = ST_UPDATE;
                end else if (!div_run_q) begin
                    div_start = 1'b1;
                    div_run_d = 1'b1;
                end else if (div_done) begin
                    new_hi_d  = div_quot;
                    div_run_d = 1'b0;
                    state_d   = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                class_1_d = new_lo_q;
                class_2_d = new_hi_q;
                iter_d    = iter_q + 4'd1;
                lo_sum_d  = '0;
                hi_sum_d  = '0;
                lo_cnt_d  = '0;
                hi_cnt_d  = '0;
                pix_idx_d = '0;
                if (converged || (iter_q + 4'd1) == MAX_ITER_C) begin
                    drst_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_RUN: begin
                if (start) begin
                    en_d    = 1'b0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_SOF;
                end else if (drst_q) begin
                    en_d   = 1'b1;             // decider leaves reset this cycle
                    busy_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (acc_en) begin
            if (is_dark) begin
                lo_sum_d = lo_sum_q + SUM_W'(luma_ch);
                lo_cnt_d = lo_cnt_q + CNT_W'(1);
            end else begin
                hi_sum_d = hi_sum_q + SUM_W'(luma_ch);
                hi_cnt_d = hi_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pix_idx_q <= '0;
            lo_sum_q  <= '0;
            hi_sum_q  <= '0;
            lo_cnt_q  <= '0;
            hi_cnt_q  <= '0;
            new_lo_q  <= INIT_C1;
            new_hi_q  <= INIT_C2;
            class_1_q <= INIT_C1;
            class_2_q <= INIT_C2;
            iter_q    <= '0;
            div_run_q <= 1'b0;
            en_q      <= 1'b0;
            drst_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_idx_q <= pix_idx_d;
            lo_sum_q  <= lo_sum_d;
            hi_sum_q  <= hi_sum_d;
            lo_cnt_q  <= lo_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            new_lo_q  <= new_lo_d;
            new_hi_q  <= new_hi_d;
            class_1_q <= class_1_d;
            class_2_q <= class_2_d;
            iter_q    <= iter_d;
            div_run_q <= div_run_d;
            en_q      <= en_d;
            drst_q    <= drst_d;
            busy_q    <= busy_d;
        end
    end

    assign class_1     = class_1_q;
    assign class_2     = class_2_q;
    assign decide_en   = en_q;
    assign decider_rst = drst_q;
    assign busy        = busy_q;
    assign iter_cnt    = iter_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_luma_threshold_scheduler.sv
// Bench for luma_threshold_scheduler: two instances (default iteration cap
// and a cap of 2 with zero tolerance) see the same pixel stream and are
// compared against a frame-level isodata model.
module tb_luma_threshold_scheduler;
  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;
  localparam int SETTLE = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sof, pix_valid;
  logic [7:0] luma_ch;
  logic [7:0] o_c1[2];
  logic [7:0] o_c2[2];
  logic       o_en[2];
  logic       o_drst[2];
  logic       o_busy[2];
  logic [3:0] o_iter[2];
  logic [2:0] o_dbg[2];

  luma_threshold_scheduler #(
    .IMAGE_WIDTH(W), .IMAGE_HIGHT(H), .MAX_ITER(8), .CONV_TOL(1),
    .INIT_C1(8'd64), .INIT_C2(8'd192)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .sof(sof), .pix_valid(pix_valid),
    .luma_ch(luma_ch), .class_1(o_c1[0]), .class_2(o_c2[0]),
    .decide_en(o_en[0]), .decider_rst(o_drst[0]), .busy(o_busy[0]),
    .iter_cnt(o_iter[0]), .dbg_state(o_dbg[0])
  );

  luma_threshold_scheduler #(
    .IMAGE_WIDTH(W), .IMAGE_HIGHT(H), .MAX_ITER(2), .CONV_TOL(0),
    .INIT_C1(8'd64), .INIT_C2(8'd192)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .sof(sof), .pix_valid(pix_valid),
    .luma_ch(luma_ch), .class_1(o_c1[1]), .class_2(o_c2[1]),
    .decide_en(o_en[1]), .decider_rst(o_drst[1]), .busy(o_busy[1]),
    .iter_cnt(o_iter[1]), .dbg_state(o_dbg[1])
  );

  // ---------------- scoreboard ----------------
  int    n_vec = 0;
  int    n_err = 0;
  string scen = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s got=%0d exp=%0d", scen, tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int pix[N];
  int m_c1[2], m_c2[2], m_iter[2], m_pulses[2];
  bit m_cal[2], m_run[2];
  int max_it[2] = '{8, 2};
  int tol[2]    = '{1, 0};
  int pulses[2] = '{0, 0};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_c1[k] = 64; m_c2[k] = 192; m_iter[k] = 0;
      m_cal[k] = 0; m_run[k] = 0;
    end
  endfunction

  function automatic void model_start();
    for (int k = 0; k < 2; k++)
      if (!m_cal[k]) begin
        m_cal[k] = 1; m_run[k] = 0; m_iter[k] = 0;
      end
  endfunction

  // One isodata iteration over the whole frame in pix[].
  function automatic void model_frame(int k);
    int th, s1, n1, s2, n2, nc1, nc2, d1, d2;
    th = (m_c1[k] / 2) + (m_c2[k] / 2);
    s1 = 0; n1 = 0; s2 = 0; n2 = 0;
    for (int i = 0; i < N; i++)
      if (pix[i] < th) begin s1 += pix[i]; n1++; end
      else begin s2 += pix[i]; n2++; end
    nc1 = (n1 != 0) ? s1 / n1 : m_c1[k];
    nc2 = (n2 != 0) ? s2 / n2 : m_c2[k];
    d1 = (nc1 > m_c1[k]) ? nc1 - m_c1[k] : m_c1[k] - nc1;
    d2 = (nc2 > m_c2[k]) ? nc2 - m_c2[k] : m_c2[k] - nc2;
    m_iter[k]++;
    m_c1[k] = nc1; m_c2[k] = nc2;
    if ((d1 <= tol[k] && d2 <= tol[k]) || m_iter[k] == max_it[k]) begin
      m_cal[k] = 0; m_run[k] = 1; m_pulses[k]++;
    end
  endfunction

  task automatic check_all(input string where);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s:k%0d:class_1", where, k), o_c1[k], m_c1[k]);
      chk($sformatf("%s:k%0d:class_2", where, k), o_c2[k], m_c2[k]);
      chk($sformatf("%s:k%0d:iter_cnt", where, k), o_iter[k], m_iter[k]);
      chk($sformatf("%s:k%0d:decide_en", where, k), o_en[k], m_run[k]);
      chk($sformatf("%s:k%0d:busy", where, k), o_busy[k], m_cal[k]);
      chk($sformatf("%s:k%0d:rst_pulses", where, k), pulses[k], m_pulses[k]);
    end
  endtask

  // decider_rst pulse counter and enable-ordering monitor
  logic prev_en[2]   = '{1'b0, 1'b0};
  logic prev_drst[2] = '{1'b0, 1'b0};
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (o_drst[k] === 1'b1) pulses[k] <= pulses[k] + 1;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_en[k] === 1'b1 && prev_en[k] === 1'b0)
        chk($sformatf("en_after_drst:k%0d", k), prev_drst[k], 1'b1);
      prev_en[k]   = o_en[k];
      prev_drst[k] = o_drst[k];
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void fill_two_level();
    for (int i = 0; i < N; i++) pix[i] = ((i % W) < W / 2) ? 40 : 200;
  endfunction

  function automatic void fill_uniform(int v);
    for (int i = 0; i < N; i++) pix[i] = v;
  endfunction

  function automatic void fill_ramp();
    int v;
    for (int i = 0; i < N; i++) begin
      v = (i * 256) / N + $urandom_range(0, 15);
      pix[i] = (v > 255) ? 255 : v;
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b0; sof = 1'b0;
    model_start();
    @(negedge clk);
    start = 1'b0;
    check_all("after_start");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; pix_valid = 1'b0; sof = 1'b0; start = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Streams pix[] as one frame; optional start pulse or reset at a pixel.
  task automatic drive_frame(input bit gapped, input int start_at, input int rst_at);
    bit counted[2];
    for (int k = 0; k < 2; k++) counted[k] = m_cal[k];
    for (int i = 0; i < N; i++) begin
      if (gapped)
        while ($urandom_range(0, 1) == 0) begin
          @(negedge clk);
          pix_valid = 1'b0; start = 1'b0;
          sof = 1'($urandom_range(0, 1));
          luma_ch = 8'($urandom_range(0, 255));
        end
      @(negedge clk);
      pix_valid = 1'b1;
      sof = (i == 0);
      luma_ch = 8'(pix[i]);
      start = (i == start_at);
      if (i == start_at) model_start();
      if (i == rst_at) begin
        #1 rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("async_rst:k%0d:class_1", k), o_c1[k], 64);
          chk($sformatf("async_rst:k%0d:class_2", k), o_c2[k], 192);
          chk($sformatf("async_rst:k%0d:decide_en", k), o_en[k], 0);
          chk($sformatf("async_rst:k%0d:iter_cnt", k), o_iter[k], 0);
          chk($sformatf("async_rst:k%0d:busy", k), o_busy[k], 0);
        end
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; start = 1'b0;
        return;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; sof = 1'b0; start = 1'b0;
    repeat (SETTLE) @(negedge clk);
    for (int k = 0; k < 2; k++) if (counted[k]) model_frame(k);
    check_all("frame_end");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f;
    rst = 1'b0; start = 1'b0; sof = 1'b0; pix_valid = 1'b0; luma_ch = 8'd0;
    model_reset();
    m_pulses = '{0, 0};
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    @(negedge clk);

    scen = "two_level";
    fill_two_level();
    pulse_start();
    drive_frame(0, -1, -1);
    chk("f1_class_1", o_c1[0], 40);
    chk("f1_class_2", o_c2[0], 200);
    drive_frame(0, -1, -1);
    chk("f2_iter", o_iter[0], 2);
    chk("f2_en", o_en[0], 1);
    drive_frame(0, -1, -1);

    scen = "valid_gaps";
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) drive_frame(1, -1, -1);
    chk("class_1", o_c1[0], 40);
    chk("class_2", o_c2[0], 200);
    chk("iter", o_iter[0], 2);

    scen = "empty_class";
    do_reset();
    fill_uniform(250);
    pulse_start();
    drive_frame(0, -1, -1);
    chk("f1_class_1", o_c1[0], 64);
    chk("f1_class_2", o_c2[0], 250);
    drive_frame(0, -1, -1);
    chk("f2_iter", o_iter[0], 2);
    chk("f2_en", o_en[0], 1);

    scen = "max_iter";
    do_reset();
    pulse_start();
    fill_ramp(); drive_frame(0, -1, -1);
    fill_ramp(); drive_frame(0, -1, -1);
    chk("capped_iter", o_iter[1], 2);
    chk("capped_en", o_en[1], 1);
    f = 2;
    while (m_cal[0] && f < 8) begin
      fill_ramp(); drive_frame(0, -1, -1); f++;
    end

    scen = "recal_from_run";
    pulse_start();
    chk("en_dropped", o_en[0], 0);
    chk("iter_cleared", o_iter[0], 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; sof = 1'b0; luma_ch = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    pix_valid = 1'b0;
    chk("waits_sof_state", o_dbg[0], 32'(luma_threshold_scheduler_pkg::ST_WAIT_SOF));
    check_all("waiting_sof");
    fill_two_level();
    drive_frame(0, 500, -1);
    drive_frame(0, -1, -1);
    drive_frame(0, -1, -1);

    scen = "reset_mid_frame";
    pulse_start();
    drive_frame(0, -1, 1000);
    check_all("after_rst");
    pulse_start();
    for (int i = 0; i < 3; i++) drive_frame(0, -1, -1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_class_1", k), o_c1[k], 40);
      chk($sformatf("k%0d_class_2", k), o_c2[k], 200);
      chk($sformatf("k%0d_iter", k), o_iter[k], 2);
      chk($sformatf("k%0d_en", k), o_en[k], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
